// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch: one sram-like read per PC, flush-safe, returns inst to IF/ID
// Optional fetch-wait performance counter enabled by defining INST_FETCH_PERF_EN.
module inst_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
`ifdef INST_FETCH_PERF_EN
    output logic [31:0]       fetch_wait_cnt_o,
`endif
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [31:0]       pc_excep_i,
    input  logic              flush_i,
    input  logic              pipe_stall_i,
    output logic              inst_req_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    input  logic [DATA_W-1:0] inst_rdata_i,
    output logic              inst_stall_o,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic [31:0]       excep_type_o
);

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DONE    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       excep_q, excep_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_REQ;
            inst_q  <= '0;
            pc_q    <= '0;
            excep_q <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            excep_q <= excep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        excep_d = excep_q;
        case (state_q)
            ST_REQ: begin
                // A flush wins: the PC is about to jump, so nothing is issued this cycle.
                if (flush_i) begin
                    state_d = ST_REQ;
                end else if (pc_excep_i[31]) begin
                    state_d = ST_DONE;
                    inst_d  = NOP_INST;
                    pc_d    = pc_i;
                    excep_d = pc_excep_i;
                end else if (inst_addr_ok_i) begin
                    state_d = ST_WAIT;
                    pc_d    = pc_i;
                    excep_d = pc_excep_i;
                end
            end
            ST_WAIT: begin
                if (inst_data_ok_i) begin
                    if (flush_i) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DONE;
                        inst_d  = inst_rdata_i;
                    end
                end else if (flush_i) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                // The read is still in flight on the bus; drain it before issuing again.
                if (inst_data_ok_i) begin
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                if (flush_i || !pipe_stall_i) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    assign inst_req_o   = !rst && (state_q == ST_REQ) && !pc_excep_i[31] && !flush_i;
    assign inst_addr_o  = pc_i;
    assign inst_stall_o = (state_q != ST_DONE);
    assign inst_valid_o = (state_q == ST_DONE);
    assign inst_o       = inst_q;
    assign inst_pc_o    = pc_q;
    assign excep_type_o = excep_q;

`ifdef INST_FETCH_PERF_EN
    logic [31:0] fetch_wait_cnt_q, fetch_wait_cnt_d;

    always_comb begin
        fetch_wait_cnt_d = fetch_wait_cnt_q;
        if (state_q != ST_DONE) begin
            fetch_wait_cnt_d = fetch_wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_wait_cnt_q <= '0;
        end else begin
            fetch_wait_cnt_q <= fetch_wait_cnt_d;
        end
    end

    assign fetch_wait_cnt_o = fetch_wait_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - vector table plus scoreboard bench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = 32'hbfc0_0000;
    logic [31:0] pc_excep_i = '0;
    logic        flush_i = 1'b0;
    logic        pipe_stall_i = 1'b0;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i = 1'b0;
    logic        inst_data_ok_i = 1'b0;
    logic [31:0] inst_rdata_i = '0;
    logic        inst_stall_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [31:0] excep_type_o;
`ifdef INST_FETCH_PERF_EN
    logic [31:0] fetch_wait_cnt;
`endif

    inst_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
`ifdef INST_FETCH_PERF_EN
        .fetch_wait_cnt_o(fetch_wait_cnt),
`endif
        .pc_i           (pc_i),
        .pc_excep_i     (pc_excep_i),
        .flush_i        (flush_i),
        .pipe_stall_i   (pipe_stall_i),
        .inst_req_o     (inst_req_o),
        .inst_addr_o    (inst_addr_o),
        .inst_addr_ok_i (inst_addr_ok_i),
        .inst_data_ok_i (inst_data_ok_i),
        .inst_rdata_i   (inst_rdata_i),
        .inst_stall_o   (inst_stall_o),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
        .excep_type_o   (excep_type_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] excep;
        logic [31:0] rdata;
        logic [31:0] exp_inst;
        int          addr_dly;
        int          data_dly;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] excep;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: each rising edge of inst_valid_o must match the oldest expected fetch.
    always @(posedge clk) begin
        #2;
        if (inst_valid_o && !prev_valid) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_valid: got inst %h pc %h expected no output", inst_o, inst_pc_o);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_inst", inst_o, mon_e.inst);
                chk("sb_pc", inst_pc_o, mon_e.pc);
                chk("sb_excep", excep_type_o, mon_e.excep);
            end
        end
        prev_valid = inst_valid_o;
    end

    task automatic run_fetch(input vec_t v);
`ifdef INST_FETCH_PERF_EN
        logic [31:0] c0;
        logic [31:0] waits;
`endif
        @(negedge clk);
        pc_i           = v.pc;
        pc_excep_i     = v.excep;
        flush_i        = 1'b0;
        pipe_stall_i   = 1'b0;
        inst_data_ok_i = 1'b0;
        inst_addr_ok_i = 1'b0;
        sb.push_back('{v.exp_inst, v.pc, v.excep});
`ifdef INST_FETCH_PERF_EN
        c0 = fetch_wait_cnt;
`endif
        if (v.excep[31]) begin
            #1;
            chk("excep_no_req", {31'd0, inst_req_o}, 32'd1 - 32'd1);
            chk("excep_stall", {31'd0, inst_stall_o}, 32'd1);
            chk("first_valid", {31'd0, inst_valid_o}, 32'd0);
        end else begin
            for (int c = 0; c <= v.addr_dly; c++) begin
                if (c > 0) @(negedge clk);
                inst_addr_ok_i = (c == v.addr_dly);
                #1;
                chk("req_held", {31'd0, inst_req_o}, 32'd1);
                chk("addr_held", inst_addr_o, v.pc);
                chk("stall_req", {31'd0, inst_stall_o}, 32'd1);
                if (c == 0) chk("first_valid", {31'd0, inst_valid_o}, 32'd0);
            end
            for (int d = 0; d <= v.data_dly; d++) begin
                @(negedge clk);
                inst_addr_ok_i = 1'b0;
                inst_data_ok_i = (d == v.data_dly);
                inst_rdata_i   = v.rdata;
                #1;
                chk("wait_no_req", {31'd0, inst_req_o}, 32'd0);
                chk("stall_wait", {31'd0, inst_stall_o}, 32'd1);
            end
        end
        @(negedge clk);
        inst_data_ok_i = 1'b0;
        inst_addr_ok_i = 1'b0;
        pipe_stall_i   = (v.hold > 0);
        #1;
        chk("done_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("done_stall", {31'd0, inst_stall_o}, 32'd0);
        chk("done_no_req", {31'd0, inst_req_o}, 32'd0);
`ifdef INST_FETCH_PERF_EN
        waits = v.excep[31] ? 32'd1 : 32'(v.addr_dly + v.data_dly + 2);
        chk("perf_cnt", fetch_wait_cnt, c0 + waits);
`endif
        for (int h = 1; h <= v.hold; h++) begin
            @(negedge clk);
            pipe_stall_i = (h < v.hold);
            #1;
            chk("hold_valid", {31'd0, inst_valid_o}, 32'd1);
            chk("hold_inst", inst_o, v.exp_inst);
            chk("hold_pc", inst_pc_o, v.pc);
            chk("hold_no_req", {31'd0, inst_req_o}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{32'hbfc0_0000, 32'h0000_0000, 32'h3c00_0001, 32'h3c00_0001, 0, 0, 0};
        vecs[1] = '{32'hbfc0_0004, 32'h0000_0000, 32'h2408_0005, 32'h2408_0005, 4, 0, 0};
        vecs[2] = '{32'hbfc0_0008, 32'h0000_0000, 32'h8d09_0010, 32'h8d09_0010, 1, 2, 3};
        vecs[3] = '{32'hbfc0_0002, 32'h8000_0000, 32'hffff_ffff, 32'h0000_0000, 0, 0, 0};
        vecs[4] = '{32'hbfc0_000c, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1, 1, 0};
        vecs[5] = '{32'hbfc0_0010, 32'h0000_0400, 32'hcafe_f00d, 32'hcafe_f00d, 0, 0, 1};

        // Reset state, request suppressed while rst is high
        @(negedge clk);
        inst_addr_ok_i = 1'b0;
        #1;
        chk("rst_req", {31'd0, inst_req_o}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_pc", inst_pc_o, 32'd0);
        chk("rst_excep", excep_type_o, 32'd0);
        chk("rst_stall", {31'd0, inst_stall_o}, 32'd1);
`ifdef INST_FETCH_PERF_EN
        chk("rst_perf", fetch_wait_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_fetch(vecs[i]);

        // Flush in WAIT, data two cycles later is dropped; flush in DISCARD ignored
        @(negedge clk);
        pc_i = 32'hbfc0_0020; pc_excep_i = '0; inst_addr_ok_i = 1'b1;
        @(negedge clk);
        inst_addr_ok_i = 1'b0; flush_i = 1'b1;
        #1 chk("flushwait_no_req", {31'd0, inst_req_o}, 32'd0);
        @(negedge clk);
        pc_i = 32'hbfc0_0380; flush_i = 1'b1;
        #1 chk("discard_no_req", {31'd0, inst_req_o}, 32'd0);
        @(negedge clk);
        flush_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'hdead_beef;
        #1 chk("discard_no_req2", {31'd0, inst_req_o}, 32'd0);
        run_fetch('{32'hbfc0_0380, 32'h0, 32'h4080_6000, 32'h4080_6000, 0, 0, 0});

        // Flush together with data_ok in WAIT drops the data
        @(negedge clk);
        pc_i = 32'hbfc0_0040; inst_addr_ok_i = 1'b1;
        @(negedge clk);
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'hbadc_0de0; flush_i = 1'b1;
        run_fetch('{32'hbfc0_0380, 32'h0, 32'h0000_0021, 32'h0000_0021, 0, 1, 0});

        // Flush in REQ suppresses the request; stray data_ok in REQ is ignored
        @(negedge clk);
        pc_i = 32'hbfc0_0050; flush_i = 1'b1;
        #1 chk("flushreq_no_req", {31'd0, inst_req_o}, 32'd0);
        @(negedge clk);
        flush_i = 1'b0; pc_i = 32'hbfc0_0380; inst_data_ok_i = 1'b1; inst_rdata_i = 32'h0bad_0bad;
        #1 chk("stray_data_req", {31'd0, inst_req_o}, 32'd1);
        run_fetch('{32'hbfc0_0380, 32'h0, 32'h2010_0007, 32'h2010_0007, 0, 0, 0});

        // Flush in DONE overrides pipe_stall
        sb.push_back('{32'h1111_2222, 32'hbfc0_0070, 32'h0});
        @(negedge clk);
        pc_i = 32'hbfc0_0070; inst_addr_ok_i = 1'b1;
        @(negedge clk);
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'h1111_2222;
        @(negedge clk);
        inst_data_ok_i = 1'b0; pipe_stall_i = 1'b1; flush_i = 1'b1;
        #1 chk("flushdone_valid", {31'd0, inst_valid_o}, 32'd1);
        @(negedge clk);
        flush_i = 1'b0; pipe_stall_i = 1'b0; pc_i = 32'hbfc0_0380;
        #1;
        chk("flushdone_req", {31'd0, inst_req_o}, 32'd1);
        chk("flushdone_invalid", {31'd0, inst_valid_o}, 32'd0);

        // Async reset mid-transaction returns to REQ with cleared outputs
        @(negedge clk);
        inst_addr_ok_i = 1'b1;
        @(negedge clk);
        inst_addr_ok_i = 1'b0; rst = 1'b1;
        #1;
        chk("midrst_req", {31'd0, inst_req_o}, 32'd0);
        chk("midrst_pc", inst_pc_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_fetch('{32'hbfc0_0380, 32'h0, 32'h0000_0042, 32'h0000_0042, 0, 0, 0});

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
